// File: rtl/writeback_queue.sv
// In-order writeback retire queue between the memory stage and the register-file write port,
// with a youngest-match forwarding lookup for decode.
module writeback_queue #(
  parameter int REG_WIDTH = 16,
  parameter int IDX_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int LINK_REG  = 7
) (
  input  logic                           I_CLOCK,
  input  logic                           I_RESET,
  input  logic                           I_Valid,
  input  logic                           I_WbEn,
  input  logic                           I_SelMem,
  input  logic                           I_IsLink,
  input  logic [IDX_WIDTH-1:0]           I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]           I_ALUOut,
  input  logic [REG_WIDTH-1:0]           I_MemOut,
  input  logic                           I_Flush,
  input  logic                           I_WbReady,
  input  logic [IDX_WIDTH-1:0]           I_FwdRegIdx,
  output logic                           O_WriteBackEnable,
  output logic [IDX_WIDTH-1:0]           O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]           O_WriteBackData,
  output logic                           O_Full,
  output logic [$clog2(DEPTH+1)-1:0]     O_Count,
  output logic                           O_FwdHit,
  output logic [REG_WIDTH-1:0]           O_FwdData,
  output logic                           O_Overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_WIDTH-1:0] idx_q  [DEPTH];
  logic [REG_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push_req, push, pop;
  logic [PTR_W-1:0]     slot;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = I_Valid & I_WbEn & ~I_Flush;
  assign push     = push_req & ~full;
  assign pop      = ~empty & I_WbReady & ~I_Flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q | (push_req & full);
    if (I_Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      vld_d   = '0;
    end else begin
      if (push) begin
        vld_d[tail_q] = 1'b1;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry payload carries no reset; validity is tracked solely by vld_q/count_q.
  always_ff @(posedge I_CLOCK) begin
    if (push) begin
      idx_q[tail_q]  <= I_IsLink ? IDX_WIDTH'(LINK_REG) : I_DestRegIdx;
      data_q[tail_q] <= I_SelMem ? I_MemOut : I_ALUOut;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    O_FwdHit  = 1'b0;
    O_FwdData = '0;
    slot      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if (vld_q[slot] && (idx_q[slot] == I_FwdRegIdx)) begin
        O_FwdHit  = 1'b1;
        O_FwdData = data_q[slot];
      end
    end
  end

  assign O_WriteBackEnable = ~empty;
  assign O_WriteBackRegIdx = empty ? '0 : idx_q[head_q];
  assign O_WriteBackData   = empty ? '0 : data_q[head_q];
  assign O_Full            = full;
  assign O_Count           = count_q;
  assign O_Overflow        = ovf_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: queue-level reference model compared every cycle,
// plus hand-computed literal expectations.
module tb_writeback_queue;
  localparam int RW = 16;
  localparam int IW = 4;
  localparam int D  = 4;
  localparam int LR = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          I_Valid = 1'b0, I_WbEn = 1'b0, I_SelMem = 1'b0, I_IsLink = 1'b0;
  logic [IW-1:0] I_DestRegIdx = '0, I_FwdRegIdx = '0;
  logic [RW-1:0] I_ALUOut = '0, I_MemOut = '0;
  logic          I_Flush = 1'b0, I_WbReady = 1'b0;
  logic          O_WriteBackEnable, O_Full, O_FwdHit, O_Overflow;
  logic [IW-1:0] O_WriteBackRegIdx;
  logic [RW-1:0] O_WriteBackData, O_FwdData;
  logic [2:0]    O_Count;

  always #5 clk = ~clk;

  writeback_queue #(.REG_WIDTH(RW), .IDX_WIDTH(IW), .DEPTH(D), .LINK_REG(LR)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_Valid(I_Valid), .I_WbEn(I_WbEn),
    .I_SelMem(I_SelMem), .I_IsLink(I_IsLink), .I_DestRegIdx(I_DestRegIdx),
    .I_ALUOut(I_ALUOut), .I_MemOut(I_MemOut), .I_Flush(I_Flush),
    .I_WbReady(I_WbReady), .I_FwdRegIdx(I_FwdRegIdx),
    .O_WriteBackEnable(O_WriteBackEnable), .O_WriteBackRegIdx(O_WriteBackRegIdx),
    .O_WriteBackData(O_WriteBackData), .O_Full(O_Full), .O_Count(O_Count),
    .O_FwdHit(O_FwdHit), .O_FwdData(O_FwdData), .O_Overflow(O_Overflow)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [RW-1:0] data;
  } ent_t;

  ent_t mq[$];
  logic m_ovf = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {idx,data}.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf <= 1'b0;
    end else if (I_Flush) begin
      mq.delete();
    end else if (mq.size() < D) begin
      if (mq.size() != 0 && I_WbReady) void'(mq.pop_front());
      if (I_Valid && I_WbEn)
        mq.push_back({(I_IsLink ? IW'(LR) : I_DestRegIdx), (I_SelMem ? I_MemOut : I_ALUOut)});
    end else begin
      if (I_Valid && I_WbEn) m_ovf <= 1'b1;
      if (I_WbReady) void'(mq.pop_front());
    end
  end

  function automatic logic [IW-1:0] m_idx();
    if (mq.size() == 0) return '0;
    return mq[0].idx;
  endfunction

  function automatic logic [RW-1:0] m_data();
    if (mq.size() == 0) return '0;
    return mq[0].data;
  endfunction

  function automatic logic [RW:0] m_fwd(input logic [IW-1:0] k);
    logic [RW:0] r;
    r = '0;
    foreach (mq[i]) if (mq[i].idx == k) r = {1'b1, mq[i].data};
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_wb_en",   32'(O_WriteBackEnable), 32'(mq.size() != 0));
      chk("m_wb_idx",  32'(O_WriteBackRegIdx), 32'(m_idx()));
      chk("m_wb_data", 32'(O_WriteBackData),   32'(m_data()));
      chk("m_full",    32'(O_Full),            32'(mq.size() == D));
      chk("m_count",   32'(O_Count),           32'(mq.size()));
      chk("m_fwd_hit", 32'(O_FwdHit),          32'(m_fwd(I_FwdRegIdx) >> RW));
      chk("m_fwd_dat", 32'(O_FwdData),         32'(m_fwd(I_FwdRegIdx) & {1'b0, {RW{1'b1}}}));
      chk("m_ovf",     32'(O_Overflow),        32'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic wb, input logic sm, input logic lk, input logic [IW-1:0] d,
                     input logic [RW-1:0] alu, input logic [RW-1:0] mem);
    I_Valid = 1'b1; I_WbEn = wb; I_SelMem = sm; I_IsLink = lk;
    I_DestRegIdx = d; I_ALUOut = alu; I_MemOut = mem;
  endtask

  task automatic idle();
    I_Valid = 1'b0; I_WbEn = 1'b0; I_SelMem = 1'b0; I_IsLink = 1'b0; I_Flush = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_wb_en", 32'(O_WriteBackEnable), 32'h0);
    chk("rst_count", 32'(O_Count), 32'h0);
    chk("rst_fwd",   32'(O_FwdHit), 32'h0);
    chk("rst_data",  32'(O_WriteBackData), 32'h0);

    // Valid without write enable is ignored
    drv(1'b0, 1'b0, 1'b0, 4'd6, 16'h7777, 16'h0); cyc(); idle(); #1;
    chk("nowb_count", 32'(O_Count), 32'h0);

    // ADD r3 = 0x1234, drained immediately
    I_WbReady = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 4'd3, 16'h1234, 16'h0); cyc(); idle(); #1;
    chk("add_en",   32'(O_WriteBackEnable), 32'h1);
    chk("add_idx",  32'(O_WriteBackRegIdx), 32'h3);
    chk("add_data", 32'(O_WriteBackData), 32'h1234);
    cyc();
    chk("add_empty", 32'(O_WriteBackEnable), 32'h0);

    // LDW r5 then JSR (link)
    I_WbReady = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 4'd5, 16'h0010, 16'hBEEF); cyc();
    drv(1'b1, 1'b0, 1'b1, 4'd2, 16'h0040, 16'h0); cyc(); idle(); #1;
    chk("ldw_count", 32'(O_Count), 32'h2);
    chk("ldw_idx",   32'(O_WriteBackRegIdx), 32'h5);
    chk("ldw_data",  32'(O_WriteBackData), 32'hBEEF);
    I_WbReady = 1'b1; cyc();
    chk("jsr_idx",  32'(O_WriteBackRegIdx), 32'h7);
    chk("jsr_data", 32'(O_WriteBackData), 32'h0040);
    cyc();
    chk("jsr_empty", 32'(O_WriteBackEnable), 32'h0);

    // Fill, then push while full with a simultaneous pop
    I_WbReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 1'b0, IW'(8 + i), RW'(32'hA000 + i), 16'h0); cyc();
    end
    idle(); #1;
    chk("full_flag",  32'(O_Full), 32'h1);
    chk("full_count", 32'(O_Count), 32'h4);
    drv(1'b1, 1'b0, 1'b0, 4'd12, 16'hDEAD, 16'h0); I_WbReady = 1'b1; cyc();
    idle(); I_WbReady = 1'b0; #1;
    chk("ovf_set",   32'(O_Overflow), 32'h1);
    chk("ovf_count", 32'(O_Count), 32'h3);
    chk("ovf_data",  32'(O_WriteBackData), 32'hA001);
    I_WbReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_idx", 32'(O_WriteBackRegIdx), 32'(9 + k));
      cyc();
    end
    chk("drain_empty", 32'(O_WriteBackEnable), 32'h0);

    // Forwarding picks youngest match
    I_WbReady = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 4'd4, 16'h0001, 16'h0); cyc();
    drv(1'b1, 1'b0, 1'b0, 4'd4, 16'h0002, 16'h0); cyc(); idle();
    I_FwdRegIdx = 4'd4; #1;
    chk("fwd4_hit",  32'(O_FwdHit), 32'h1);
    chk("fwd4_data", 32'(O_FwdData), 32'h0002);
    I_FwdRegIdx = 4'd6; #1;
    chk("fwd6_hit",  32'(O_FwdHit), 32'h0);
    chk("fwd6_data", 32'(O_FwdData), 32'h0);

    // Flush with a push in the same cycle
    drv(1'b1, 1'b0, 1'b0, 4'd1, 16'h5555, 16'h0); I_Flush = 1'b1; cyc(); idle(); #1;
    chk("flush_count", 32'(O_Count), 32'h0);
    chk("flush_en",    32'(O_WriteBackEnable), 32'h0);
    chk("flush_ovf",   32'(O_Overflow), 32'h1);

    // Wrap-around: 10 back-to-back push/pop pairs
    I_WbReady = 1'b1; I_FwdRegIdx = 4'd3;
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'b0, 1'b0, IW'(i), RW'(32'hC000 + i), 16'h0); cyc(); #1;
      chk("wrap_idx",  32'(O_WriteBackRegIdx), 32'(i));
      chk("wrap_data", 32'(O_WriteBackData), 32'hC000 + 32'(i));
    end
    idle(); cyc();
    chk("wrap_empty", 32'(O_WriteBackEnable), 32'h0);

    // Asynchronous reset with 3 entries queued
    I_WbReady = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 4'd2, 16'h0011, 16'h0); cyc();
    drv(1'b1, 1'b0, 1'b0, 4'd3, 16'h0022, 16'h0); cyc();
    drv(1'b1, 1'b0, 1'b0, 4'd4, 16'h0033, 16'h0); cyc(); idle(); #1;
    chk("pre_rst_count", 32'(O_Count), 32'h3);
    chk("pre_rst_fwd",   32'(O_FwdData), 32'h0022);
    #1 rst = 1'b1;
    #1;
    chk("arst_en",    32'(O_WriteBackEnable), 32'h0);
    chk("arst_count", 32'(O_Count), 32'h0);
    chk("arst_idx",   32'(O_WriteBackRegIdx), 32'h0);
    chk("arst_data",  32'(O_WriteBackData), 32'h0);
    chk("arst_fwd",   32'(O_FwdHit), 32'h0);
    chk("arst_ovf",   32'(O_Overflow), 32'h0);
    cyc(); rst = 1'b0; cyc();
    chk("post_rst_count", 32'(O_Count), 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Parametrised successor to the single-cycle writeback stage.
- Accepts pre-decoded writeback requests from the memory stage and buffers them in a DEPTH-entry in-order retire queue.
- Drains entries to the register-file write port through a valid/ready handshake.
- Provides youngest-entry forwarding lookup for decode, so that a busy register-file port no longer forces writes to be dropped or the pipeline to stall early.

Parameters:
- REG_WIDTH, 16, data width of a register.
- IDX_WIDTH, 4, register index width.
- DEPTH, 4, queue entries; power of two, >= 2.
- LINK_REG, 7, destination index forced for link (JSR/JSRR) writes.

Ports:
- I_CLOCK  in  1  clock, rising edge.
- I_RESET  in  1  asynchronous active-high reset.
- I_Valid  in  1  memory stage presents an instruction this cycle.
- I_WbEn  in  1  instruction writes a register (ADD/ADDI/MOVI/AND/ANDI/MOV/LDW/JSR/JSRR).
- I_SelMem  in  1  data source is I_MemOut (LDW); else I_ALUOut.
- I_IsLink  in  1  link write; destination becomes LINK_REG.
- I_DestRegIdx  in  IDX_WIDTH  destination register.
- I_ALUOut  in  REG_WIDTH  ALU result.
- I_MemOut  in  REG_WIDTH  load data.
- I_Flush  in  1  synchronous queue clear.
- I_WbReady  in  1  register-file port accepts head entry.
- I_FwdRegIdx  in  IDX_WIDTH  decode lookup index.
- O_WriteBackEnable  out  1  head entry valid (queue non-empty).
- O_WriteBackRegIdx  out  IDX_WIDTH  head destination.
- O_WriteBackData  out  REG_WIDTH  head data.
- O_Full  out  1  count == DEPTH; upstream must hold.
- O_Count  out  $clog2(DEPTH+1)  occupied entries.
- O_FwdHit  out  1  a queued entry targets I_FwdRegIdx.
- O_FwdData  out  REG_WIDTH  data of youngest matching entry.
- O_Overflow  out  1  sticky: push attempted while full.

Behaviour:
- Reset (async, I_RESET=1):
  - head/tail pointers and count go to 0; O_Overflow goes to 0.
  - All entry valid bits go to 0.
  - Every output reads 0 while the queue is empty.
- Push condition: I_Valid & I_WbEn & ~O_Full & ~I_Flush.
  - Stored idx = I_IsLink ? LINK_REG : I_DestRegIdx.
  - Stored data = I_SelMem ? I_MemOut : I_ALUOut. I_IsLink takes precedence over I_SelMem for the index; data follows I_SelMem.
  - I_Valid with I_WbEn=0 has no effect.
- Pop condition: O_WriteBackEnable & I_WbReady & ~I_Flush. Head advances at the clock edge.
- Head outputs: O_WriteBackRegIdx and O_WriteBackData are combinational from head storage. When empty, they are forced to 0.
- Latency: an entry pushed at edge N is visible at the head from edge N (after N) if the queue was empty. There is no same-cycle bypass of the input to the head.
- Simultaneous push and pop:
  - When not full, both occur and count is unchanged.
  - When full, the push is rejected even if a pop occurs that cycle; O_Full is combinational on count only.
- Overflow: a push attempt while full sets O_Overflow. It stays set until reset; the request is discarded.
- Flush: I_Flush=1 clears pointers, count and valid bits at the edge. It takes priority over push and pop. O_Overflow is not cleared by flush.
- Pointers: wrap modulo DEPTH. Count runs 0..DEPTH.
- Forwarding: combinational search over valid entries.
  - O_FwdHit=1 if any valid entry's idx == I_FwdRegIdx.
  - O_FwdData = data of the youngest (closest to tail) match, else 0.
  - The entry being pushed this cycle is not searched. The head being popped this cycle still matches until the edge.
- Register 0 has no special treatment.
- Reset asserted mid-drain discards all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle:
  - O_WriteBackEnable=0, O_Count=0, O_FwdHit=0, all data 0.
  - Assert I_RESET mid-queue with 3 entries -> outputs 0 immediately.
- Push ADD r3=0x1234 (SelMem=0), I_WbReady=1:
  - Next cycle: O_WriteBackEnable=1, idx=3, data=0x1234.
  - Following cycle: empty.
- Push LDW r5 with I_MemOut=0xBEEF, I_ALUOut=0x0010 -> head data 0xBEEF. Push JSR with I_DestRegIdx=2, I_ALUOut=0x0040 -> idx 7, data 0x0040.
- Hold I_WbReady=0 and push 4 entries:
  - O_Full=1, O_Count=4.
  - A 5th push with I_WbReady=1 the same cycle -> rejected, O_Overflow=1, count=3 after the edge.
  - Drain order matches push order.
- Push r4=0x0001 then r4=0x0002, ready low, I_FwdRegIdx=4 -> O_FwdHit=1, O_FwdData=0x0002. I_FwdRegIdx=6 -> hit 0.
- With 2 entries queued, assert I_Flush together with a valid push -> count=0 next cycle, push dropped, O_Overflow unchanged. Wrap-around: 10 push/pop pairs at DEPTH=4 keep order intact.
